// File: rtl/ddfs.sv
// Direct digital frequency synthesiser: phase accumulator feeding a quarter-wave sine ROM.
// Optional phase dithering via a 15-bit LFSR is enabled by defining DDFS_DITHER_EN.
`timescale 1ns/1ps

module ddfs #(
    parameter int ACC_W  = 23,
    parameter int OUT_W  = 8,
    parameter int LUT_AW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] fcontrol,
    output logic [OUT_W-1:0] outp
);

    localparam int PW  = LUT_AW + 2;
    localparam int MID = 1 << (OUT_W - 1);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PW-1:0]     phase;
    logic [1:0]        quad;
    logic [LUT_AW-1:0] romAddr;
    logic [OUT_W-2:0]  romData;
    logic [OUT_W-2:0]  mag_q;
    logic              neg_q;
    logic [OUT_W-1:0]  outp_q, outp_d;

    assign acc_d = acc_q + fcontrol;

`ifdef DDFS_DITHER_EN
    logic [14:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] idx;

    assign lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    assign idx    = acc_q + ACC_W'(lfsr_q);
    assign phase  = idx[ACC_W-1 -: PW];

    // The dithered index only addresses the ROM; the accumulator never sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 15'h0001;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign phase = acc_q[ACC_W-1 -: PW];
`endif

    assign quad    = phase[PW-1 -: 2];
    // Odd quadrants walk the quarter table backwards (63 - a).
    assign romAddr = quad[0] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];

    always_comb begin
        romData = '0;
        case (romAddr)
            6'd0:  romData = 7'd2;    6'd1:  romData = 7'd5;
            6'd2:  romData = 7'd8;    6'd3:  romData = 7'd11;
            6'd4:  romData = 7'd14;   6'd5:  romData = 7'd17;
            6'd6:  romData = 7'd20;   6'd7:  romData = 7'd23;
            6'd8:  romData = 7'd26;   6'd9:  romData = 7'd29;
            6'd10: romData = 7'd32;   6'd11: romData = 7'd35;
            6'd12: romData = 7'd38;   6'd13: romData = 7'd41;
            6'd14: romData = 7'd44;   6'd15: romData = 7'd47;
            6'd16: romData = 7'd50;   6'd17: romData = 7'd53;
            6'd18: romData = 7'd56;   6'd19: romData = 7'd58;
            6'd20: romData = 7'd61;   6'd21: romData = 7'd64;
            6'd22: romData = 7'd67;   6'd23: romData = 7'd69;
            6'd24: romData = 7'd72;   6'd25: romData = 7'd74;
            6'd26: romData = 7'd77;   6'd27: romData = 7'd79;
            6'd28: romData = 7'd82;   6'd29: romData = 7'd84;
            6'd30: romData = 7'd86;   6'd31: romData = 7'd89;
            6'd32: romData = 7'd91;   6'd33: romData = 7'd93;
            6'd34: romData = 7'd95;   6'd35: romData = 7'd97;
            6'd36: romData = 7'd99;   6'd37: romData = 7'd101;
            6'd38: romData = 7'd103;  6'd39: romData = 7'd105;
            6'd40: romData = 7'd106;  6'd41: romData = 7'd108;
            6'd42: romData = 7'd110;  6'd43: romData = 7'd111;
            6'd44: romData = 7'd113;  6'd45: romData = 7'd114;
            6'd46: romData = 7'd115;  6'd47: romData = 7'd117;
            6'd48: romData = 7'd118;  6'd49: romData = 7'd119;
            6'd50: romData = 7'd120;  6'd51: romData = 7'd121;
            6'd52: romData = 7'd122;  6'd53: romData = 7'd123;
            6'd54: romData = 7'd124;  6'd55: romData = 7'd124;
            6'd56: romData = 7'd125;  6'd57: romData = 7'd125;
            6'd58: romData = 7'd126;  6'd59: romData = 7'd126;
            6'd60: romData = 7'd127;  6'd61: romData = 7'd127;
            6'd62: romData = 7'd127;  6'd63: romData = 7'd127;
            default: romData = '0;
        endcase
    end

    // Negative half-cycle is folded around mid-scale rather than stored.
    assign outp_d = neg_q ? (OUT_W'(MID) - OUT_W'(mag_q)) : (OUT_W'(MID) + OUT_W'(mag_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            outp_q <= OUT_W'(MID);
        end else begin
            acc_q  <= acc_d;
            mag_q  <= romData;
            neg_q  <= quad[1];
            outp_q <= outp_d;
        end
    end

    assign outp = outp_q;

endmodule

// File: tb/tb_ddfs.sv
// Self-checking bench for ddfs (dither disabled): directed vectors plus a floating-point sine model.
`timescale 1ns/1ps

module tb_ddfs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [22:0] fcontrol = '0;
    logic [7:0]  outp;

    ddfs dut (
        .clk      (clk),
        .rst      (rst),
        .fcontrol (fcontrol),
        .outp     (outp)
    );

    always #50 clk = ~clk;

    localparam real PI = 3.14159265358979;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [22:0] accModel;
    int          expOut;
    int          expNext;
    int          obsBuf [1024];

    // Ideal sample for a phase, computed directly from a full-cycle sine.
    function automatic int sampleOf(input logic [22:0] acc);
        int  p;
        real v;
        p = int'(acc[22:15]);
        v = 127.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 256.0);
        if (v >= 0.0) return 128 + $rtoi(v + 0.5);
        else          return 128 - $rtoi(0.5 - v);
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        accModel = '0;
        expOut   = 128;
        expNext  = 128;
    endtask

    // Called at a falling edge; asserts reset between edges to exercise the async path.
    task automatic applyReset(input string tag);
        #20;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_async"}, int'(outp), 128);
        resetModel();
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"}, int'(outp), 128);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Iteration k checks the output after k edges since the call; starts and ends on a falling edge.
    task automatic applyStimulus(input logic [22:0] fc, input int n, input string tag, input bit capture);
        for (int k = 0; k < n; k++) begin
            checkOutput(tag, int'(outp), expOut);
            if (capture && k >= 2 && (k - 2) < 1024) obsBuf[k-2] = int'(outp);
            fcontrol = fc;
            @(posedge clk);
            expOut   = expNext;
            expNext  = sampleOf(accModel);
            accModel = accModel + fc;
            @(negedge clk);
        end
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int mx, mn, crossings;
        resetModel();
        #5 rst = 1'b1;
        #1 checkOutput("reset_state", int'(outp), 128);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(23'd0, 8, "fc_zero", 1'b1);
        checkOutput("fc_zero_first", obsBuf[0], 130);
        checkOutput("fc_zero_held", int'(outp), 130);

        applyReset("rst_ramp");
        applyStimulus(23'h008000, 300, "ramp", 1'b1);
        checkOutput("ramp_p0", obsBuf[0], 130);
        checkOutput("ramp_p1", obsBuf[1], 133);
        checkOutput("ramp_p63", obsBuf[63], 255);
        checkOutput("ramp_p64", obsBuf[64], 255);
        checkOutput("ramp_p127", obsBuf[127], 130);
        checkOutput("ramp_p128", obsBuf[128], 126);
        checkOutput("ramp_p191", obsBuf[191], 1);
        checkOutput("ramp_p192", obsBuf[192], 1);
        checkOutput("ramp_period", obsBuf[256], 130);
        mx = 0;
        mn = 1000;
        for (int p = 0; p < 256; p++) begin
            if (obsBuf[p] > mx) mx = obsBuf[p];
            if (obsBuf[p] < mn) mn = obsBuf[p];
        end
        checkOutput("ramp_max", mx, 255);
        checkOutput("ramp_min", mn, 1);
        for (int p = 0; p < 128; p++) checkOutput("sym_half", obsBuf[p] + obsBuf[p+128], 256);
        for (int p = 0; p < 64; p++)  checkOutput("sym_mirror", obsBuf[p], obsBuf[127-p]);

        applyReset("rst_nyq");
        applyStimulus(23'h400000, 40, "nyquist", 1'b1);
        checkOutput("nyq_0", obsBuf[0], 130);
        checkOutput("nyq_1", obsBuf[1], 126);
        checkOutput("nyq_2", obsBuf[2], 130);
        checkOutput("nyq_37", obsBuf[37], 126);

        applyReset("rst_f57k");
        applyStimulus(23'd57344, 1026, "f57344", 1'b1);
        checkOutput("f57k_idx2", obsBuf[2], 139);
        crossings = 0;
        mn = 1000;
        for (int i = 1; i < 1024; i++) begin
            if (obsBuf[i-1] < 128 && obsBuf[i] > 128) crossings++;
            if (obsBuf[i] < mn) mn = obsBuf[i];
        end
        checkOutput("f57k_crossings", crossings, 6);
        checkOutput("f57k_nonzero", int'(mn >= 1), 1);

        applyStimulus(23'b01110000111100001111000, 300, "fswitch", 1'b0);

        applyReset("midrun");
        applyStimulus(23'h008000, 4, "resume", 1'b1);
        checkOutput("resume_p0", obsBuf[0], 130);
        checkOutput("resume_p1", obsBuf[1], 133);

        applyStimulus(23'h7FFFFF, 65536, "wrap", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
